axi_uart_tx_initiator: RTL and testbench

AXI_UART_TX_INITIATOR -- requirements
Module: axi_uart_tx_initiator

---
 rtl/axi_uart_tx_initiator.sv | 192 +++++++++++++++++++
 tb/tb_axi_uart_tx_initiator.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uart_tx_initiator.sv
// axi_uart_tx_initiator: writes each inbound byte to a UART THR
// over AXI-Lite, one transaction at a time, registered outputs only.
// Ports: clk_i, rstn_i (async, active-low); s_data_i/s_valid_i/
// s_ready_o byte stream in; m_axi_uart_aw*/w*/b* write channels;
// m_axi_uart_ar*/r* read channels; busy_o (FSM not IDLE);
// err_o (sticky bresp/rresp error).
// Build option: UART_TX_INIT_POLL_EN polls LSR bit 5 (THRE)
// before every write; undefined writes immediately.
module axi_uart_tx_initiator #(
  parameter logic [12:0] THR_ADDR = 13'h1000,
  parameter logic [12:0] LSR_ADDR = 13'h1014,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [12:0] m_axi_uart_awaddr,
  output logic        m_axi_uart_awvalid,
  input  logic        m_axi_uart_awready,
  output logic [31:0] m_axi_uart_wdata,
  output logic [3:0]  m_axi_uart_wstrb,
  output logic        m_axi_uart_wvalid,
  input  logic        m_axi_uart_wready,
  input  logic [1:0]  m_axi_uart_bresp,
  input  logic        m_axi_uart_bvalid,
  output logic        m_axi_uart_bready,
  output logic [12:0] m_axi_uart_araddr,
  output logic        m_axi_uart_arvalid,
  input  logic        m_axi_uart_arready,
  input  logic [31:0] m_axi_uart_rdata,
  input  logic [1:0]  m_axi_uart_rresp,
  input  logic        m_axi_uart_rvalid,
  output logic        m_axi_uart_rready,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE, POLL_AR, POLL_R, GAP, WR, WB
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q;
  logic        s_ready_q, busy_q, err_q;
  logic        awvalid_q, wvalid_q, bready_q;
  logic [12:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic       s_hs, aw_hs, w_hs, b_hs;
  logic       aw_fin, w_fin, enter_wr, err_ev;
  logic [7:0] wbyte;

  assign s_hs     = s_valid_i & s_ready_q;
  assign aw_hs    = awvalid_q & m_axi_uart_awready;
  assign w_hs     = wvalid_q & m_axi_uart_wready;
  assign b_hs     = bready_q & m_axi_uart_bvalid;
  // a channel is finished once its valid has dropped or
  // its handshake happens this cycle
  assign aw_fin   = ~awvalid_q | m_axi_uart_awready;
  assign w_fin    = ~wvalid_q | m_axi_uart_wready;
  assign enter_wr = (state_d == WR) & (state_q != WR);
  // direct IDLE->WR takes the byte straight off the stream
  assign wbyte    = s_hs ? s_data_i : byte_q;

`ifdef UART_TX_INIT_POLL_EN
  localparam logic [7:0] GAP_LAST =
    (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  logic        arvalid_q, rready_q;
  logic [12:0] araddr_q;
  logic [7:0]  gap_q;
  logic        ar_hs, r_hs, thre;
  logic        unused_rd;

  assign ar_hs     = arvalid_q & m_axi_uart_arready;
  assign r_hs      = rready_q & m_axi_uart_rvalid;
  assign thre      = m_axi_uart_rdata[5];
  assign unused_rd = ^{m_axi_uart_rdata[31:6],
                       m_axi_uart_rdata[4:0]};
  assign err_ev    = (b_hs & (|m_axi_uart_bresp)) |
                     (r_hs & (|m_axi_uart_rresp));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      gap_q     <= '0;
    end else begin
      arvalid_q <= (state_d == POLL_AR);
      rready_q  <= (state_d == POLL_R);
      if (state_d == POLL_AR) araddr_q <= LSR_ADDR;
      if ((state_q == GAP) && (state_d == GAP))
        gap_q <= gap_q + 8'd1;
      else
        gap_q <= 8'd0;
    end
  end

  assign m_axi_uart_arvalid = arvalid_q;
  assign m_axi_uart_araddr  = araddr_q;
  assign m_axi_uart_rready  = rready_q;
`else
  logic unused_rd;

  assign unused_rd = ^{m_axi_uart_arready, m_axi_uart_rvalid,
                       m_axi_uart_rresp, m_axi_uart_rdata,
                       LSR_ADDR, 8'(POLL_GAP)};
  assign err_ev    = b_hs & (|m_axi_uart_bresp);

  assign m_axi_uart_arvalid = 1'b0;
  assign m_axi_uart_araddr  = '0;
  assign m_axi_uart_rready  = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef UART_TX_INIT_POLL_EN
        if (s_hs) state_d = POLL_AR;
`else
        if (s_hs) state_d = WR;
`endif
      end
`ifdef UART_TX_INIT_POLL_EN
      POLL_AR: if (ar_hs) state_d = POLL_R;
      POLL_R: begin
        if (r_hs) begin
          if (|m_axi_uart_rresp) state_d = GAP;
          else if (thre)         state_d = WR;
          else                   state_d = GAP;
        end
      end
      GAP: if (gap_q == GAP_LAST) state_d = POLL_AR;
`endif
      WR: if (aw_fin && w_fin) state_d = WB;
      WB: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      s_ready_q <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      bready_q  <= (state_d == WB);
      if (s_hs)   byte_q <= s_data_i;
      if (err_ev) err_q  <= 1'b1;
      if (enter_wr) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= THR_ADDR;
        wdata_q   <= {24'h0, wbyte};
        wstrb_q   <= 4'b0001;
      end else begin
        if (aw_hs) awvalid_q <= 1'b0;
        if (w_hs)  wvalid_q  <= 1'b0;
      end
    end
  end

  assign s_ready_o          = s_ready_q;
  assign busy_o             = busy_q;
  assign err_o              = err_q;
  assign m_axi_uart_awvalid = awvalid_q;
  assign m_axi_uart_awaddr  = awaddr_q;
  assign m_axi_uart_wvalid  = wvalid_q;
  assign m_axi_uart_wdata   = wdata_q;
  assign m_axi_uart_wstrb   = wstrb_q;
  assign m_axi_uart_bready  = bready_q;

endmodule

// File: tb/tb_axi_uart_tx_initiator.sv
// tb_axi_uart_tx_initiator: directed bench with a transaction-level
// model of the initiator and a per-cycle output compare.
module tb_axi_uart_tx_initiator;
`ifdef UART_TX_INIT_POLL_EN
  localparam bit POLL = 1'b1;
`else
  localparam bit POLL = 1'b0;
`endif
  localparam int GAPN = 4;
  localparam int GEFF = (GAPN == 0) ? 1 : GAPN;
  localparam logic [12:0] THR = 13'h1000;
  localparam logic [12:0] LSR = 13'h1014;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [12:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [12:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad = 0;

  int aw_dly = 0;
  int w_dly = 0;
  bit b_bad = 1'b0;
  logic [31:0] lsr_q[$];

  logic [31:0] w_log[$];
  logic [31:0] aw_log[$];
  int rd_cnt = 0;
  int b_cnt = 0;

  logic       m_pend = 0, m_started = 0, m_err = 0;
  logic       m_aw = 0, m_w = 0, m_lsr = 0, m_rd = 0;
  logic [7:0] m_byte = 0;
  int         m_since = 0;

  always #5 clk_i = ~clk_i;

  axi_uart_tx_initiator #(
    .THR_ADDR(THR),
    .LSR_ADDR(LSR),
    .POLL_GAP(GAPN)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .s_data_i(s_data_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_axi_uart_awaddr(awaddr),
    .m_axi_uart_awvalid(awvalid),
    .m_axi_uart_awready(awready),
    .m_axi_uart_wdata(wdata),
    .m_axi_uart_wstrb(wstrb),
    .m_axi_uart_wvalid(wvalid),
    .m_axi_uart_wready(wready),
    .m_axi_uart_bresp(bresp),
    .m_axi_uart_bvalid(bvalid),
    .m_axi_uart_bready(bready),
    .m_axi_uart_araddr(araddr),
    .m_axi_uart_arvalid(arvalid),
    .m_axi_uart_arready(arready),
    .m_axi_uart_rdata(rdata),
    .m_axi_uart_rresp(rresp),
    .m_axi_uart_rvalid(rvalid),
    .m_axi_uart_rready(rready),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] last_w();
    return (w_log.size() == 0) ? 32'hdead : w_log[w_log.size()-1];
  endfunction

  // Model: one byte in flight; tracks which channel handshakes the
  // current byte has completed and what the slave answered.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_pend <= 0; m_started <= 0; m_err <= 0;
      m_aw <= 0; m_w <= 0; m_lsr <= 0; m_rd <= 0;
      m_since <= 0;
    end else begin
      m_started <= 1;
      if (!m_pend) begin
        if (s_valid_i && s_ready_o) begin
          m_pend  <= 1;
          m_byte  <= s_data_i;
          m_aw    <= 0;
          m_w     <= 0;
          m_lsr   <= !POLL;
          m_rd    <= 0;
          m_since <= 1000;
        end
      end else begin
        if (awvalid && awready) begin
          m_aw <= 1;
          aw_log.push_back({19'h0, awaddr});
        end
        if (wvalid && wready) begin
          m_w <= 1;
          w_log.push_back(wdata);
        end
        if (bvalid && bready) begin
          m_pend <= 0;
          b_cnt  <= b_cnt + 1;
          if (bresp != 2'b00) m_err <= 1;
        end
        if (arvalid && arready) begin
          m_rd   <= 1;
          rd_cnt <= rd_cnt + 1;
        end
        if (m_rd && rvalid && rready) begin
          m_rd    <= 0;
          m_since <= 0;
          if (lsr_q.size() > 0) void'(lsr_q.pop_front());
          if (rresp != 2'b00) m_err <= 1;
          else if (rdata[5]) m_lsr <= 1;
        end else if (m_since < 1000) begin
          m_since <= m_since + 1;
        end
      end
    end
  end

  // Slave responder
  initial begin
    int aw_cnt;
    int w_cnt;
    aw_cnt = 0;
    w_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (awvalid) aw_cnt++; else aw_cnt = 0;
      if (wvalid)  w_cnt++;  else w_cnt = 0;
      awready = awvalid && (aw_cnt > aw_dly);
      wready  = wvalid && (w_cnt > w_dly);
      bvalid  = bready;
      bresp   = b_bad ? 2'b10 : 2'b00;
      arready = arvalid;
      rvalid  = m_rd;
      rdata   = (lsr_q.size() > 0) ? lsr_q[0] : 32'h60;
      rresp   = 2'b00;
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk_i);
    chk("s_ready", 32'(s_ready_o), 32'(m_started && !m_pend));
    chk("busy", 32'(busy_o), 32'(m_pend));
    chk("err", 32'(err_o), 32'(m_err));
    chk("awvalid", 32'(awvalid), 32'(m_pend && m_lsr && !m_aw));
    chk("wvalid", 32'(wvalid), 32'(m_pend && m_lsr && !m_w));
    chk("bready", 32'(bready), 32'(m_pend && m_aw && m_w));
    chk("arvalid", 32'(arvalid),
        32'(POLL && m_pend && !m_lsr && !m_rd && m_since >= GEFF));
    chk("rready", 32'(rready), 32'(POLL ? m_rd : 1'b1));
    if (awvalid) chk("awaddr", 32'(awaddr), 32'(THR));
    if (wvalid) begin
      chk("wdata", wdata, {24'h0, m_byte});
      chk("wstrb", 32'(wstrb), 32'h1);
    end
`ifdef UART_TX_INIT_POLL_EN
    if (arvalid) chk("araddr", 32'(araddr), 32'(LSR));
`else
    chk("araddr", 32'(araddr), 32'h0);
`endif
  end

  task automatic send(input logic [7:0] b);
    int n;
    logic hs;
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i = b;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 300) begin
      @(posedge clk_i);
      hs = s_ready_o;
      n++;
    end
    chk("send_hs", 32'(hs), 32'h1);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_data_i = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 400 && !(s_ready_o && !busy_o)) begin
      @(negedge clk_i);
      s_data_i = 8'($urandom);
      n++;
    end
    chk("idle_reached", 32'(s_ready_o && !busy_o), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int gaps;

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_s_ready", 32'(s_ready_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_awvalid", 32'(awvalid), 32'h0);
    chk("rst_wvalid", 32'(wvalid), 32'h0);
    chk("rst_bready", 32'(bready), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_awaddr", 32'(awaddr), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_arvalid", 32'(arvalid), 32'h0);
    @(posedge clk_i);
    #2 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rel_s_ready_0", 32'(s_ready_o), 32'h0);
    @(negedge clk_i);
    chk("rel_s_ready_1", 32'(s_ready_o), 32'h1);

    // single byte, all readies high
    send(8'h41);
`ifdef UART_TX_INIT_POLL_EN
    chk("c1_arvalid", 32'(arvalid), 32'h1);
    chk("c1_araddr", 32'(araddr), 32'h1014);
    @(negedge clk_i);
    chk("c2_rready", 32'(rready), 32'h1);
    @(negedge clk_i);
`endif
    chk("wr_awvalid", 32'(awvalid), 32'h1);
    chk("wr_wvalid", 32'(wvalid), 32'h1);
    chk("wr_awaddr", 32'(awaddr), 32'h1000);
    chk("wr_wdata", wdata, 32'h0000_0041);
    chk("wr_wstrb", 32'(wstrb), 32'h1);
    wait_idle();
    chk("b41_err", 32'(err_o), 32'h0);
    chk("b41_log", last_w(), 32'h41);

`ifdef UART_TX_INIT_POLL_EN
    // THRE clear twice, then set
    lsr_q.push_back(32'h00);
    lsr_q.push_back(32'h00);
    lsr_q.push_back(32'h20);
    base = rd_cnt;
    n = w_log.size();
    send(8'h42);
    gaps = 0;
    for (int i = 0; i < 200 && busy_o; i++) begin
      if (!arvalid && !rready && !awvalid && !wvalid && !bready)
        gaps++;
      @(negedge clk_i);
    end
    wait_idle();
    chk("poll_reads", 32'(rd_cnt - base), 32'h3);
    chk("poll_gap_cycles", 32'(gaps), 32'(2 * GAPN));
    chk("poll_writes", 32'(w_log.size() - n), 32'h1);
    chk("poll_log", last_w(), 32'h42);
`endif

    // awready 3 cycles late
    aw_dly = 3;
    base = b_cnt;
    send(8'hA5);
    wait_idle();
    aw_dly = 0;
    chk("awlate_b", 32'(b_cnt - base), 32'h1);
    chk("awlate_log", last_w(), 32'hA5);

    // wready late
    w_dly = 2;
    send(8'h3C);
    wait_idle();
    w_dly = 0;
    chk("wlate_log", last_w(), 32'h3C);

    // bresp error, then normal byte
    b_bad = 1'b1;
    send(8'h55);
    wait_idle();
    b_bad = 1'b0;
    chk("berr_set", 32'(err_o), 32'h1);
    send(8'h56);
    wait_idle();
    chk("berr_sticky", 32'(err_o), 32'h1);
    chk("after_err_log", last_w(), 32'h56);

    // reset while in WR
    aw_dly = 50;
    w_dly = 50;
    send(8'h77);
    n = 0;
    while (!awvalid && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("pre_rst_awvalid", 32'(awvalid), 32'h1);
    chk("pre_rst_err", 32'(err_o), 32'h1);
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_awvalid", 32'(awvalid), 32'h0);
    chk("arst_wvalid", 32'(wvalid), 32'h0);
    chk("arst_err", 32'(err_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    aw_dly = 0;
    w_dly = 0;
    @(posedge clk_i);
    #2 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("arel_s_ready_0", 32'(s_ready_o), 32'h0);
    @(negedge clk_i);
    chk("arel_s_ready_1", 32'(s_ready_o), 32'h1);

    // back-to-back bytes
    base = w_log.size();
    n = aw_log.size();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    wait_idle();
    chk("b2b_count", 32'(w_log.size() - base), 32'h3);
    chk("b2b_aw_count", 32'(aw_log.size() - n), 32'h3);
    if (w_log.size() >= base + 3) begin
      chk("b2b_0", w_log[base], 32'h01);
      chk("b2b_1", w_log[base+1], 32'h02);
      chk("b2b_2", w_log[base+2], 32'h03);
    end
    if (aw_log.size() >= n + 3)
      chk("b2b_awaddr", aw_log[n+2], 32'h1000);
    chk("b2b_err", 32'(err_o), 32'h0);

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
